// File: rtl/perm_sram_reader.sv
// +--------------------------------------------------------------------+
// | perm_sram_reader                                                   |
// | Reads a 1..N scramble table from async SRAM, validates it as a     |
// | permutation, builds the inverse table and streams it valid/ready.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module perm_sram_reader #(
  parameter int N           = 32,
  parameter int BASE_ADDR   = 1,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addressbus,
  input  logic [DATA_W-1:0] databus_in,
  output logic              ce,
  output logic              oe,
  output logic              we,
  output logic              lsb,
  output logic              msb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(N + 1);
  localparam int TBL   = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SETUP, S_RD_WAIT, S_RD_CAPTURE,
    S_RD_GAP, S_STREAM, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] i_nxt;
  logic [2:0]       wcnt;
  logic             rd_n;
  logic [TBL-1:0]   seen;
  logic [IDX_W-1:0] inv [TBL];
  logic [IDX_W-1:0] v_idx;
  logic             v_bad;

  // The full data word is range-checked; only the low bits index the tables.
  assign v_idx = databus_in[IDX_W-1:0];
  assign v_bad = (databus_in == '0) || (databus_in > DATA_W'(N)) || seen[v_idx];
  assign i_nxt = i + IDX_W'(1);

  assign ce  = rd_n;
  assign oe  = rd_n;
  assign lsb = rd_n;
  assign msb = rd_n;
  assign we  = 1'b1;

  always_ff @(posedge clk) begin
    if (state == S_RD_CAPTURE && !v_bad)
      inv[v_idx] <= k;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addressbus <= '0;
      rd_n       <= 1'b1;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      seen       <= '0;
      k          <= '0;
      i          <= '0;
      wcnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            seen       <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            k          <= IDX_W'(1);
            addressbus <= BASE;
            rd_n       <= 1'b0;
            state      <= S_RD_SETUP;
          end
        end
        S_RD_SETUP: begin
          wcnt  <= 3'(WAIT_STATES);
          state <= (WAIT_STATES == 0) ? S_RD_CAPTURE : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wcnt <= 3'd1) state <= S_RD_CAPTURE;
          else              wcnt  <= wcnt - 3'd1;
        end
        S_RD_CAPTURE: begin
          rd_n <= 1'b1;
          if (v_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERROR;
          end else begin
            seen[v_idx] <= 1'b1;
            state       <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          if (k == IDX_W'(N)) begin
            i         <= IDX_W'(1);
            out_data  <= DATA_W'(inv[IDX_W'(1)]);
            out_valid <= 1'b1;
            state     <= S_STREAM;
          end else begin
            // Old k equals the next entry's offset from BASE.
            k          <= k + IDX_W'(1);
            addressbus <= BASE + ADDR_W'(k);
            rd_n       <= 1'b0;
            state      <= S_RD_SETUP;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (i == IDX_W'(N)) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              i        <= i_nxt;
              out_data <= DATA_W'(inv[i_nxt]);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_perm_sram_reader.sv
// +--------------------------------------------------------------------+
// | tb_perm_sram_reader                                                |
// | Table-driven scoreboard bench for perm_sram_reader (WS = 1, 0, 3). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_perm_sram_reader;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       st, rdy, ce, oe, we, lsb, msb, ov, busy, done, err;
  logic [2:0][17:0] ab;
  logic [2:0][15:0] db, od;
  logic [15:0]      mem [64];
  logic [15:0]      exp_q [$];
  int               checks = 0;
  int               failures = 0;
  int               cur = 0;

  typedef struct {
    int inst;
    int kind;
    int mode;
    bit exp_err;
    int words;
    int maxa;
  } vec_t;
  vec_t vt [10];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    int ocnt;
    perm_sram_reader #(.N(N), .BASE_ADDR(1), .WAIT_STATES(WS), .ADDR_W(18), .DATA_W(16)) u_dut (
      .clk(clk), .reset(reset), .start(st[g]), .addressbus(ab[g]), .databus_in(db[g]),
      .ce(ce[g]), .oe(oe[g]), .we(we[g]), .lsb(lsb[g]), .msb(msb[g]),
      .out_data(od[g]), .out_valid(ov[g]), .out_ready(rdy[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g]));
    // SRAM whose data only becomes valid after oe has been low for WS+1 cycles
    always @(posedge clk) ocnt <= oe[g] ? 0 : ocnt + 1;
    assign db[g] = (!ce[g] && !oe[g] && ocnt >= WS + 1) ? mem[ab[g][5:0]] : 16'hFFFF;
  end

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 0 : 3;
  endfunction

  function automatic logic [15:0] exp_val(input int kind, input int idx);
    if (kind == 1) return 16'(33 - idx);
    if (kind == 6) return (idx == 1) ? 16'd32 : 16'(idx - 1);
    return 16'(idx);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_table(input int kind);
    for (int a = 0; a < 64; a++) mem[a] = 16'd0;
    for (int kk = 1; kk <= N; kk++) begin
      if (kind == 1)                  mem[kk] = 16'(33 - kk);
      else if (kind == 6 || kind == 7) mem[kk] = 16'((kk % 32) + 1);
      else                            mem[kk] = 16'(kk);
    end
    case (kind)
      2: mem[7] = mem[3];
      3: mem[1] = 16'd0;
      4: mem[1] = 16'd33;
      5: mem[5] = 16'h0105;
      7: mem[7] = mem[3];
      default: ;
    endcase
  endtask

  task automatic rst_chk(input int g);
    chk("reset_state",
        {ab[g], ce[g], oe[g], we[g], lsb[g], msb[g], od[g], ov[g], busy[g], done[g], err[g]},
        {18'd0, 5'b11111, 16'd0, 4'b0000});
  endtask

  // Caller is positioned on a falling edge.
  task automatic run_vec(input vec_t v);
    int ws, rd_cyc, vcyc, words, maxa, oemin, oemax, run, xfers, sbad;
    bit holding, errseen, finished;
    logic [15:0] held;
    ws = ws_of(v.inst);
    rd_cyc = 0; vcyc = 0; words = 0; maxa = 0; oemin = 999; oemax = 0;
    run = 0; xfers = 0; sbad = 0; holding = 0; errseen = 0; finished = 0; held = '0;
    load_table(v.kind);
    if (!v.exp_err)
      for (int n = 1; n <= N; n++) exp_q.push_back(exp_val(v.kind, n));
    cur = v.inst;
    st[cur] = 1'b1;
    @(negedge clk);
    st[cur] = 1'b0;
    chk("start_state", {busy[cur], done[cur], err[cur]}, 3'b100);
    for (int c = 0; c < 2000 && !finished; c++) begin
      if (c > 0) @(negedge clk);
      rdy[cur] = (v.mode == 0) ? 1'b1 : (c % 2 == 0);
      if (busy[cur] && !ov[cur]) rd_cyc++;
      if (ce[cur] != oe[cur] || lsb[cur] != oe[cur] || msb[cur] != oe[cur]) sbad++;
      if (!oe[cur]) begin
        run++;
        if (int'(ab[cur]) > maxa) maxa = int'(ab[cur]);
      end else if (run > 0) begin
        words++;
        if (run < oemin) oemin = run;
        if (run > oemax) oemax = run;
        run = 0;
      end
      if (ov[cur]) begin
        vcyc++;
        if (holding) chk("stall_hold", od[cur], held);
        if (rdy[cur]) begin
          holding = 0;
          xfers++;
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else chk("out_data", od[cur], exp_q.pop_front());
        end else begin
          holding = 1;
          held = od[cur];
        end
      end else if (holding) begin
        chk("valid_dropped", 1, 0);
        holding = 0;
      end
      if (err[cur] && !errseen) begin
        errseen = 1;
        chk("err_strobes_high", {ce[cur], oe[cur]}, 2'b11);
      end
      if (done[cur]) finished = 1;
    end
    if (!finished) chk("timeout", 0, 1);
    chk("err", err[cur], v.exp_err);
    chk("busy_end", busy[cur], 0);
    chk("valid_at_done", ov[cur], 0);
    chk("xfers", xfers, v.exp_err ? 0 : N);
    chk("words", words, v.words);
    chk("max_addr", maxa, v.maxa);
    chk("oe_min", oemin, ws + 2);
    chk("oe_max", oemax, ws + 2);
    chk("strobe_sync", sbad, 0);
    chk("we_high", we[cur], 1);
    if (!v.exp_err) chk("read_cycles", rd_cyc, N * (ws + 3));
    if (v.mode == 0 && !v.exp_err) chk("stream_cycles", vcyc, N);
    if (v.exp_err) chk("no_valid", vcyc, 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    st = '0;
    rdy = '0;
    vt[0] = '{0, 0, 0, 0, 32, 32};
    vt[1] = '{0, 1, 1, 0, 32, 32};
    vt[2] = '{0, 2, 0, 1, 7, 7};
    vt[3] = '{0, 3, 0, 1, 1, 1};
    vt[4] = '{0, 4, 0, 1, 1, 1};
    vt[5] = '{0, 5, 0, 1, 5, 5};
    vt[6] = '{0, 0, 1, 0, 32, 32};
    vt[7] = '{1, 6, 0, 0, 32, 32};
    vt[8] = '{2, 6, 1, 0, 32, 32};
    vt[9] = '{2, 7, 0, 1, 7, 7};
    load_table(0);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst_chk(g);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 10; n++) run_vec(vt[n]);

    // Mid-busy start must be ignored; async reset lands during word 15.
    cur = 0;
    load_table(0);
    rdy[0] = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_mid", busy[0], 1);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    c = 21;
    while (!(ab[0] == 18'd15 && !oe[0]) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("addr15_reached", (ab[0] == 18'd15 && !oe[0]), 1);
    #2 reset = 1'b1;
    #1 rst_chk(0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec(vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perm_sram_reader.md
# perm_sram_reader

Read-side counterpart of the logistic-map permutation generator. After `start`, the block reads the 32-entry scramble table from the external asynchronous SRAM (words 1..32), checks that it is a true permutation of 1..32, and builds the inverse table. It then streams the inverse indices over a valid/ready interface to the pixel de-scrambler in the decryption path.

## Interface
- `N`, 32: table length; legal entry values are 1..N.
- `BASE_ADDR`, 1: SRAM address of table entry 1; entry k is at `BASE_ADDR+k-1`.
- `WAIT_STATES`, 1: extra cycles `oe` is held low before data is sampled (0..7).
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `addressbus`  out  ADDR_W  SRAM address, registered.
- `databus_in`  in  DATA_W  SRAM read data.
- `ce`, `oe`, `we`, `lsb`, `msb`  out  1 each  SRAM strobes, active-low.
- `out_data`  out  DATA_W  inverse index (1..N), zero-extended.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts.
- `busy`  out  1  high from start acceptance until DONE or ERROR.
- `done`  out  1  sticky; set on completion or error, cleared by next accepted start.
- `err`  out  1  sticky; table invalid, cleared by next accepted start.

## Operation
- Reset values: `addressbus`=0, `ce`=`oe`=`we`=`lsb`=`msb`=1, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `err`=0, state IDLE, seen bits cleared.
- `we` is tied high: the block never writes the SRAM.
- States: IDLE, RD_SETUP, RD_WAIT, RD_CAPTURE, RD_GAP, STREAM, DONE, ERROR.
- IDLE, `start`=1: clear seen[1..N] and `err`/`done`; set k=1, `busy`=1; go to RD_SETUP.
- RD_SETUP: drive `addressbus`=`BASE_ADDR+k-1` and `ce`=`oe`=`lsb`=`msb`=0. Go to RD_WAIT, or to RD_CAPTURE if `WAIT_STATES`=0.
- RD_WAIT: hold for `WAIT_STATES` cycles, then go to RD_CAPTURE.
- RD_CAPTURE: sample `v=databus_in`.
  - If v<1, v>N, or seen[v]=1: go to ERROR.
  - Otherwise set seen[v]=1 and inv[v]=k, then go to RD_GAP.
- RD_GAP: strobes high for 1 turnaround cycle. If k=N, go to STREAM with i=1; else k=k+1 and go to RD_SETUP.
- STREAM: `out_valid`=1, `out_data`=inv[i].
  - On `out_valid`&`out_ready`, i=i+1.
  - After the transfer of i=N, go to DONE.
- DONE: `busy`=0, `done`=1; wait for `start`.
- ERROR: strobes high, `err`=1, `done`=1, `busy`=0, no streaming; wait for `start`.
- `start` outside IDLE/DONE/ERROR is ignored. `start` in DONE or ERROR behaves as in IDLE.
- Width rules: `out_data` upper bits are zero. The full `databus_in` word is range-checked, so bits above 5 set give an error.

## Timing
- Word period: `WAIT_STATES`+3 cycles (setup, waits, capture, gap). `oe` is low for `WAIT_STATES`+2 consecutive cycles per word.
- Read phase: N*(`WAIT_STATES`+3) cycles; 128 with defaults.
- `addressbus` is stable while `oe` is low. Data is sampled on the rising edge that ends RD_CAPTURE.
- First `out_valid` is 1 cycle after the last RD_GAP.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_data` is held stable. `out_valid` never drops before its transfer. With `out_ready` tied high, one index transfers per cycle.
- `out_valid` falls in the cycle after the N-th transfer; `done` rises in that same cycle.
- Error: strobes are high in the cycle after the offending capture; `err`=1 in that same cycle.
- Reset mid-operation: all outputs take reset values asynchronously; the state machine restarts in IDLE.

## Test plan
- Identity table (mem[1+k-1]=k, k=1..32), `out_ready`=1 -> `out_data` 1,2,…,32 on consecutive cycles; `done`=1, `err`=0; 128 read cycles.
- Reversed table (mem=33-k) with `out_ready` toggling 1,0,1,0 -> stream 32,31,…,1; `out_data` is stable through every stall; no index is lost or repeated.
- Duplicate: entry 7 = value of entry 3 -> `err`=1 after the 7th capture; `ce`/`oe` high the next cycle; `out_valid` never asserted; no address beyond `BASE_ADDR`+6 is driven.
- Out-of-range: entry 1 = 0, then rerun with entry 1 = 33 -> `err`=1 in both runs. A following `start` with a valid table clears `err` and completes.
- `WAIT_STATES`=0 and `WAIT_STATES`=3 -> `oe`-low widths of 2 and 5 cycles. An SRAM model that returns data late by `WAIT_STATES` cycles still reads correctly.
- Async `reset` asserted at word 15 of the read, plus `start` pulsed while `busy` -> all outputs at reset values immediately; the mid-busy `start` has no effect; a fresh `start` after reset completes normally.
